// File: rtl/bus_pkg.sv
// Shared types and decode constants for the 68000 bus responder.
package bus_pkg;
  typedef enum logic [2:0] {IDLE, DECODE, ACCESS, HOLD, ACK, BERR} state_t;
  typedef enum logic [1:0] {PROM, SRAM, NONE} region_t;

  localparam logic [3:0] PROM_HI_NIBBLE = 4'h0;
  localparam logic [3:0] SRAM_HI_NIBBLE = 4'h1;
endpackage

// File: rtl/bus_responder_sync2.sv
// Two-flop synchronizer with a selectable reset value.
module sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic gclk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge gclk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/bus_responder.sv
// 68000 bus target: decodes chip selects/strobes, inserts wait states,
// raises DTACK_N or BERR_N, and can hold each cycle for a STEP press.
module bus_responder
  import bus_pkg::*;
#(
  parameter int PROM_WAIT  = 2,
  parameter int SRAM_WAIT  = 1,
  parameter int DS_TIMEOUT = 64
) (
  input  logic        MCLK,
  input  logic        RESET,
  input  logic        AS_N,
  input  logic        UDS_N,
  input  logic        LDS_N,
  input  logic        RW,
  input  logic [23:1] A,
  input  logic        STEPEN,
  input  logic        STEP,
  output logic        DTACK_N,
  output logic        BERR_N,
  output logic        PROMCS0,
  output logic        PROMCS1,
  output logic        SRAMCS0,
  output logic        SRAMCS1,
  output logic        OE_N,
  output logic        WE_N,
  output logic        RUN
);
  localparam logic [3:0] PW = 4'(PROM_WAIT);
  localparam logic [3:0] SW = 4'(SRAM_WAIT);
  localparam logic [7:0] TO_LAST = 8'(DS_TIMEOUT - 1);

  logic sas_n, suds_n, slds_n, srw, sstep;

  sync2 #(.RST_VAL(1'b1)) u_as  (.gclk(MCLK), .rst(RESET), .d(AS_N),  .q(sas_n));
  sync2 #(.RST_VAL(1'b1)) u_uds (.gclk(MCLK), .rst(RESET), .d(UDS_N), .q(suds_n));
  sync2 #(.RST_VAL(1'b1)) u_lds (.gclk(MCLK), .rst(RESET), .d(LDS_N), .q(slds_n));
  sync2 #(.RST_VAL(1'b1)) u_rw  (.gclk(MCLK), .rst(RESET), .d(RW),    .q(srw));
  sync2 #(.RST_VAL(1'b0)) u_stp (.gclk(MCLK), .rst(RESET), .d(STEP),  .q(sstep));

  function automatic region_t decode(input logic [3:0] nib);
    case (nib)
      PROM_HI_NIBBLE: return PROM;
      SRAM_HI_NIBBLE: return SRAM;
      default:        return NONE;
    endcase
  endfunction

  state_t      state, state_d;
  region_t     region, region_d;
  logic [1:0]  lanes, lanes_d;   // {upper, lower}, 1 = lane selected
  logic        rw_q, rw_d;
  logic [3:0]  wcnt, wcnt_d;
  logic [7:0]  tcnt, tcnt_d;
  logic        step_prev;
  logic [1:0]  sync_vld;
  logic        armed;
  logic        act;
  logic        unused_a;

  assign unused_a = ^A[19:1];

  always_comb begin
    state_d  = state;
    region_d = region;
    lanes_d  = lanes;
    rw_d     = rw_q;
    wcnt_d   = wcnt;
    tcnt_d   = tcnt;
    case (state)
      IDLE:
        if (armed && !sas_n) begin
          tcnt_d  = '0;
          state_d = DECODE;
        end
      DECODE:
        if (sas_n) state_d = IDLE;
        else if (!suds_n || !slds_n) begin
          region_d = decode(A[23:20]);
          if (region_d == NONE) state_d = BERR;
          else begin
            state_d = ACCESS;
            lanes_d = {!suds_n, !slds_n};
            rw_d    = srw;
            wcnt_d  = (region_d == PROM) ? PW : SW;
          end
        end else if (tcnt == TO_LAST) state_d = BERR;
        else tcnt_d = tcnt + 8'd1;
      ACCESS:
        if (sas_n) state_d = IDLE;
        else if (wcnt == 4'd0) state_d = STEPEN ? HOLD : ACK;
        else wcnt_d = wcnt - 4'd1;
      HOLD:
        if (sas_n) state_d = IDLE;
        else if (!STEPEN || (sstep && !step_prev)) state_d = ACK;
      ACK, BERR:
        if (sas_n) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign act = (state_d == ACCESS) || (state_d == HOLD) || (state_d == ACK);

  // Outputs come from next-state so they change on the same edge as the state.
  always_ff @(posedge MCLK) begin
    if (RESET) begin
      state     <= IDLE;
      region    <= NONE;
      lanes     <= '0;
      rw_q      <= 1'b1;
      wcnt      <= '0;
      tcnt      <= '0;
      step_prev <= 1'b0;
      sync_vld  <= '0;
      armed     <= 1'b0;
      DTACK_N   <= 1'b1;
      BERR_N    <= 1'b1;
      PROMCS0   <= 1'b1;
      PROMCS1   <= 1'b1;
      SRAMCS0   <= 1'b1;
      SRAMCS1   <= 1'b1;
      OE_N      <= 1'b1;
      WE_N      <= 1'b1;
      RUN       <= 1'b1;
    end else begin
      state     <= state_d;
      region    <= region_d;
      lanes     <= lanes_d;
      rw_q      <= rw_d;
      wcnt      <= wcnt_d;
      tcnt      <= tcnt_d;
      step_prev <= sstep;
      // AS must be seen high once the synchronizer holds real samples
      sync_vld  <= {sync_vld[0], 1'b1};
      armed     <= armed | (sync_vld[1] & sas_n);
      DTACK_N   <= !(state_d == ACK);
      BERR_N    <= !(state_d == BERR);
      RUN       <= !(state_d == HOLD);
      PROMCS0   <= !(act && region_d == PROM && lanes_d[1]);
      PROMCS1   <= !(act && region_d == PROM && lanes_d[0]);
      SRAMCS0   <= !(act && region_d == SRAM && lanes_d[1]);
      SRAMCS1   <= !(act && region_d == SRAM && lanes_d[0]);
      OE_N      <= !(act && rw_d);
      WE_N      <= !(act && !rw_d);
    end
  end
endmodule
